serial_fa_sequencer: RTL and testbench
======================================

Name: serial_fa_sequencer

Overview:
- Bit-serial adder controller that sits both upstream and downstream of the team's 1-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in, then feeds the cell one bit pair per clock, LSB first, driving its a/b/c inputs.
- Registers the cell's carry output back into the next bit, assembles the sum bits into a parallel result, and reports completion.
- Converts the combinational 1-bit adder into a WIDTH-bit adder with WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  request new addition; accepted only when ready=1
op_a  in  WIDTH  operand A, sampled on accepted start
op_b  in  WIDTH  operand B, sampled on accepted start
cin  in  1  initial carry, sampled on accepted start
ready  out  1  1 in IDLE or DONE (start will be accepted)
busy  out  1  1 in RUN
done  out  1  one-cycle pulse: result/cout valid
result  out  WIDTH  sum, held until next accepted start
cout  out  1  final carry, held with result
fa_a  out  1  to full-adder cell, operand A bit
fa_b  out  1  to full-adder cell, operand B bit
fa_c  out  1  to full-adder cell, carry-in
fa_s  in  1  from full-adder cell, sum bit
fa_co  in  1  from full-adder cell, carry-out

Behaviour:
Interface:
- One clock (clk).
- Reset rst_n is synchronous and active-low: sampled only on the rising edge of clk; rst_n=0 resets the block on that edge.

Reset:
- State=IDLE, shift regs=0, carry reg=0, bit counter=0.
- Outputs: result=0, cout=0, done=0, busy=0, ready=1, fa_a/fa_b/fa_c=0.
- Reset mid-RUN aborts the operation; no done pulse; result cleared to 0.

State machine:
- IDLE: ready=1. start=1 -> load sh_a<=op_a, sh_b<=op_b, carry<=cin, count<=0, result<=0 -> RUN.
- RUN, one bit per cycle:
  - fa_a=sh_a[0], fa_b=sh_b[0], fa_c=carry (combinational from registers, no input-to-output path).
  - Each edge: result<={fa_s, result[WIDTH-1:1]}, carry<=fa_co, sh_a/sh_b shift right, count++.
  - When count==WIDTH-1 on an edge -> DONE, cout<=fa_co.
  - start is ignored in RUN (no effect, no queueing).
- DONE: done=1 for exactly this cycle; ready=1.
  - start=1 -> reload and RUN (back-to-back, no IDLE gap).
  - Otherwise -> IDLE.
- fa_a/fa_b/fa_c are 0 outside RUN.

Timing:
- Latency: start accepted on edge k -> RUN cycles between edges k..k+WIDTH -> done=1 in the cycle after edge k+WIDTH.
- Throughput: one addition per WIDTH+1 cycles.

Arithmetic:
- {cout,result} = op_a + op_b + cin, unsigned, modulo 2^(WIDTH+1).
- Wrap-around: all-ones + 1 gives result=0, cout=1.
- Operand changes after acceptance have no effect on the running addition.

Optional Feature:
Macro: SERIAL_FA_OVERFLOW_EN
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - On the final RUN edge, ovf<=carry ^ fa_co (carry into MSB XOR carry out of MSB) = two's-complement signed overflow.
  - Held with result; cleared to 0 on accepted start.
- Not defined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset, WIDTH=8: rst_n=0 for 2 cycles -> ready=1, busy=0, done=0, result=0x00, fa_a/fa_b/fa_c=0.
- Basic adds, checked 9 cycles after start (fa_* wired to a behavioural full adder):
  - 0x5A+0x3C, cin=0 -> result=0x96, cout=0, ovf=1.
  - 0x00+0x00, cin=1 -> result=0x01, cout=0.
- Wrap: 0xFF+0x01, cin=0 -> result=0x00, cout=1, ovf=0. Then 0x80+0x80 -> result=0x00, cout=1, ovf=1.
- Handshake: start held high during RUN with different operands -> ignored, exactly one done per accepted start. start asserted in the DONE cycle -> busy=1 next cycle, second result correct after 9 more cycles.
- Reset mid-operation: rst_n=0 at bit 4 of 0x7F+0x01 -> IDLE, result=0, no done. A new start then yields 0x80, cout=0.
- Randomised check: 200 random operand/cin triples compared against the reference sum for result/cout; done pulse width always 1 cycle.

Source files
------------

// File: rtl/serial_fa_sequencer.sv
// Bit-serial WIDTH-bit adder controller around an external 1-bit full-adder cell.
// Optional SERIAL_FA_OVERFLOW_EN adds a signed-overflow flag (ovf).
module serial_fa_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
`ifdef SERIAL_FA_OVERFLOW_EN
    input  logic             fa_co,
    output logic             ovf
`else
    input  logic             fa_co
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sh_a, sh_b;
    logic             carry;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last;

    assign last = (count == LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                fa_a = sh_a[0];
                fa_b = sh_b[0];
                fa_c = carry;
                if (last) state_d = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            sh_a   <= op_a;
            sh_b   <= op_b;
            carry  <= cin;
            count  <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state_q == RUN) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            carry  <= fa_co;
            count  <= count + 1'b1;
            result <= {fa_s, result[WIDTH-1:1]};
            if (last) cout <= fa_co;
        end
    end

`ifdef SERIAL_FA_OVERFLOW_EN
    // Carry into the MSB is still in the carry register on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n)                        ovf <= 1'b0;
        else if (accept)                   ovf <= 1'b0;
        else if (state_q == RUN && last)   ovf <= carry ^ fa_co;
    end
`endif

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Self-checking bench for serial_fa_sequencer, WIDTH=8, with a behavioural
// full-adder cell and an arithmetic reference model.
module tb_serial_fa_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic         ready, busy, done, cout;
    logic [W-1:0] result;
    logic         fa_a, fa_b, fa_c, fa_s, fa_co;
`ifdef SERIAL_FA_OVERFLOW_EN
    logic         ovf;
`endif

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    assign fa_s  = fa_a ^ fa_b ^ fa_c;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_fa_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .ready(ready), .busy(busy), .done(done),
        .result(result), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
`ifdef SERIAL_FA_OVERFLOW_EN
        .fa_s(fa_s), .fa_co(fa_co), .ovf(ovf)
`else
        .fa_s(fa_s), .fa_co(fa_co)
`endif
    );

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit hold);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Waits for done, checks latency and the sum against plain arithmetic
    task automatic wait_done(input string tag, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic c,
                             input bit hold);
        int n;
        logic [W:0] s;
        logic sov;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        sov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        n = 1;
        while (done !== 1'b1 && n <= 2 * W) begin
            if (hold) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                cin  = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, W + 1);
        check({tag, "_result"}, {24'd0, result}, {24'd0, s[W-1:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, s[W]});
`ifdef SERIAL_FA_OVERFLOW_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, sov});
`else
        if (sov === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic add_once(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic c);
        launch(a, b, c, 1'b0);
        wait_done(tag, a, b, c, 1'b0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int d0;
        logic [W-1:0] ra, rb;
        logic rc;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_c}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        add_once("basic1", 8'h5A, 8'h3C, 1'b0);
        add_once("basic2", 8'h00, 8'h00, 1'b1);
        add_once("wrap1", 8'hFF, 8'h01, 1'b0);
        add_once("wrap2", 8'h80, 8'h80, 1'b0);

        // start held high through RUN with changing operands
        d0 = done_cnt;
        launch(8'h12, 8'h34, 1'b1, 1'b1);
        check("hold_busy", {31'd0, busy}, 32'd1);
        wait_done("hold", 8'h12, 8'h34, 1'b1, 1'b1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_one_done", done_cnt - d0, 1);

        // back-to-back start in the DONE cycle
        launch(8'hA5, 8'h0F, 1'b0, 1'b0);
        wait_done("b2b_a", 8'hA5, 8'h0F, 1'b0, 1'b0);
        launch(8'hC3, 8'h7E, 1'b1, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_b", 8'hC3, 8'hC3 == 8'h0 ? 8'h0 : 8'h7E, 1'b1, 1'b0);
        @(negedge clk);

        // reset in the middle of a run
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", {24'd0, result}, 32'd0);
        repeat (W + 2) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        add_once("after_rst", 8'h7F, 8'h01, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            add_once("rand", ra, rb, rc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
